// File: rtl/cache_rr_arbiter.sv
// Round-robin arbiter granting the cache datapath to one of W requesters; grant registered 1 cycle after req.
// Grant held until done or watchdog abort; losers simply keep req asserted (no other backpressure).
module cache_rr_decoder #(
    parameter int N = 3,
    parameter int W = 1 << N
) (
    input  logic [N-1:0] i_sel,
    input  logic         i_en,
    output logic [W-1:0] o_dec
);
    always_comb begin
        o_dec = '0;
        if (i_en) o_dec[i_sel] = 1'b1;
    end
endmodule

module cache_rr_arbiter #(
    parameter int N       = 3,
    parameter int W       = 1 << N,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req,
    input  logic         done,
    output logic         gnt_valid,
    output logic [N-1:0] gnt_index,
    output logic [W-1:0] gnt_onehot,
    output logic         busy,
    output logic         timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t        r_state;
    logic [N-1:0]  r_ptr;
    logic [N-1:0]  r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    logic          w_any;
    logic [N-1:0]  w_win;
    logic [N-1:0]  w_scan;

    // Scan from the farthest offset down to ptr so the last hit is the nearest one.
    always_comb begin
        w_any  = 1'b0;
        w_win  = r_ptr;
        w_scan = '0;
        for (int i = W - 1; i >= 0; i--) begin
            w_scan = r_ptr + N'(i);
            if (req[w_scan]) begin
                w_any = 1'b1;
                w_win = w_scan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_BUSY;
                        r_idx   <= w_win;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
                    if (done) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_idx + 1'b1;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                        r_ptr     <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_valid = (r_state == ST_BUSY);
    assign busy      = (r_state == ST_BUSY);
    assign gnt_index = r_idx;
    assign timeout   = r_timeout;

    cache_rr_decoder #(.N(N), .W(W)) u_dec (
        .i_sel (r_idx),
        .i_en  (r_state == ST_BUSY),
        .o_dec (gnt_onehot)
    );
endmodule

// File: doc/cache_rr_arbiter.md
Name: cache_rr_arbiter

Overview:
Round-robin arbiter that shares the single cache-controller datapath among W requesters. It registers one winner and drives both the binary grant index and the one-hot grant vector; the one-hot vector is produced by an internal instance of the team's decoder (N-to-2^N). The grant is held until the datapath signals completion, or until a watchdog timeout aborts it. The block sits between the requester ports and the cache controller's request mux.

Parameters:
N, 3, width of the grant index; number of requesters W = 2^N.
W, 1<<N, number of requesters. Must equal 2^N.
TIMEOUT, 16, maximum cycles a grant may stay in BUSY without done; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
req  input  W  per-requester request; bit i high = requester i wants the cache.
done  input  1  single-cycle pulse from the datapath: the current granted transaction is complete.
gnt_valid  output  1  high while a grant is outstanding.
gnt_index  output  N  binary index of the granted requester; meaningful only when gnt_valid=1.
gnt_onehot  output  W  decoder(gnt_index) gated by gnt_valid; all zeros when gnt_valid=0.
busy  output  1  high in state BUSY; identical to gnt_valid.
timeout  output  1  one-cycle pulse when a grant is aborted by the watchdog.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, gnt_valid=0, gnt_index=0, gnt_onehot=0, busy=0, timeout=0.
  - Priority pointer ptr=0; watchdog counter cnt=0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ..., wrapping mod W.
  - On the next edge: gnt_index=winner, gnt_valid=1, state=BUSY, cnt=0.
  - If req==0: stay in IDLE, outputs unchanged.
  - done in IDLE is ignored.
- Latency: req sampled high at edge k gives gnt_valid=1 after edge k+1, i.e. 1 cycle.
- BUSY:
  - gnt_index and gnt_onehot are frozen. Changes on req, including withdrawal by the granted requester, have no effect.
  - cnt increments every cycle; width is $clog2(TIMEOUT+1), and it saturates, never wraps.
  - done=1: next edge gives state=IDLE, gnt_valid=0, ptr=(gnt_index+1) mod W.
  - done=0 and cnt==TIMEOUT-1: next edge gives state=IDLE, gnt_valid=0, timeout=1 for exactly one cycle, ptr=(gnt_index+1) mod W.
  - done and the timeout condition in the same cycle: done wins and timeout stays 0.
- Back-to-back:
  - At least one IDLE cycle separates grants.
  - The earliest next gnt_valid is 2 edges after the edge that sampled done.
- Fairness:
  - ptr wraps from W-1 to 0.
  - A continuously requesting requester is granted within W grants.
- Reset asserted mid-BUSY:
  - All outputs clear immediately, without waiting for clk.
  - ptr returns to 0 and the in-flight grant is discarded.
- gnt_onehot:
  - Combinational from registered gnt_index and gnt_valid, through the decoder instance.
  - Exactly one bit is set when gnt_valid=1.

Test Plan:
- Reset: rst=1 with req=8'hFF → gnt_valid=0, gnt_onehot=8'h00, timeout=0; release rst → gnt_index=0, gnt_onehot=8'h01 one edge later.
- Rotation: hold req=8'hFF, pulse done 2 cycles after each grant → gnt_index sequence 0,1,...,7,0 and gnt_onehot 01,02,...,80,01, with one IDLE cycle between grants.
- Sparse and wrap: after a grant to 6 (ptr=7), set req=8'b0000_0101 → grant 0, then after done grant 2, then 0 again.
- Hold and freeze: grant requester 3, then drop req[3] and raise req[5] while BUSY → gnt_index stays 3 until done; requester 5 is granted 2 edges after done.
- Watchdog: TIMEOUT=16, grant with no done → gnt_valid falls after 16 BUSY cycles, timeout pulses once and the next requester is served; repeat with done asserted on cycle 16 → no timeout pulse.
- Async reset mid-BUSY: assert rst between clock edges → outputs clear before the next edge; first grant after release uses ptr=0.
